// File: rtl/spi_sync_frontend.sv
`timescale 1ns/1ps
// SPI mode-0 slave front end: oversamples sck/ss_n/sdi in the clk domain,
// deserialises MOSI bytes, serialises MISO bytes and tracks frame boundaries.
module spi_sync_frontend #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        ss_n,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_first,
  input  logic [7:0]  tx_data,
  output logic        tx_req,
  output logic        frame_end,
  output logic        rx_abort,
  output logic [15:0] byte_count
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  localparam logic [2:0] FLUSH_CYCLES = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sck_d;
  logic                   r_ss_d;
  logic [2:0]             r_flush_cnt;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_rx_shift;
  logic [7:0]  r_tx_shift;
  logic [2:0]  r_bit_cnt;
  logic        r_first;
  logic        r_load_pend;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_first;
  logic        r_tx_req;
  logic        r_frame_end;
  logic        r_rx_abort;
  logic [15:0] r_byte_count;

  logic       w_sck;
  logic       w_ss;
  logic       w_sdi;
  logic       w_ready;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_ss_fall;
  logic       w_ss_rise;
  logic       w_start;
  logic       w_stop;
  logic       w_act;
  logic [7:0] w_rx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_sdi_sync  <= '0;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
      r_flush_cnt <= 3'd0;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
      r_ss_d     <= r_ss_sync[SYNC_STAGES-1];
      if (r_flush_cnt != FLUSH_CYCLES) begin
        r_flush_cnt <= r_flush_cnt + 3'd1;
      end
    end
  end

  assign w_sck = r_sck_sync[SYNC_STAGES-1];
  assign w_ss  = r_ss_sync[SYNC_STAGES-1];
  assign w_sdi = r_sdi_sync[SYNC_STAGES-1];

  // Edges are masked until the reset idle levels have left the chain, so a
  // select held low across reset cannot masquerade as a fresh falling edge.
  assign w_ready    = (r_flush_cnt == FLUSH_CYCLES);
  assign w_sck_rise = w_ready &  w_sck & ~r_sck_d;
  assign w_sck_fall = w_ready & ~w_sck &  r_sck_d;
  assign w_ss_fall  = w_ready & ~w_ss  &  r_ss_d;
  assign w_ss_rise  = w_ready &  w_ss  & ~r_ss_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_ss_fall) w_state_next = S_ACTIVE;
      S_ACTIVE: if (w_ss_rise) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  assign w_start   = (r_state == S_IDLE) & w_ss_fall;
  assign w_stop    = (r_state == S_ACTIVE) & w_ss_rise;
  assign w_act     = (r_state == S_ACTIVE) & ~w_ss_rise & ~w_ss_fall;
  assign w_rx_next = {r_rx_shift[6:0], w_sdi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_shift   <= 8'h00;
      r_tx_shift   <= 8'h00;
      r_bit_cnt    <= 3'd0;
      r_first      <= 1'b0;
      r_load_pend  <= 1'b0;
      r_rx_data    <= 8'h00;
      r_rx_valid   <= 1'b0;
      r_rx_first   <= 1'b0;
      r_tx_req     <= 1'b0;
      r_frame_end  <= 1'b0;
      r_rx_abort   <= 1'b0;
      r_byte_count <= 16'h0000;
    end else begin
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_tx_req    <= 1'b0;
      r_frame_end <= 1'b0;
      r_rx_abort  <= 1'b0;
      if (w_start) begin
        r_tx_shift   <= tx_data;
        r_bit_cnt    <= 3'd0;
        r_byte_count <= 16'h0000;
        r_first      <= 1'b1;
        r_load_pend  <= 1'b0;
      end else if (w_stop) begin
        r_frame_end <= 1'b1;
        r_rx_abort  <= (r_bit_cnt != 3'd0);
        r_bit_cnt   <= 3'd0;
        r_load_pend <= 1'b0;
      end else if (w_act) begin
        if (w_sck_rise) begin
          r_rx_shift <= w_rx_next;
          r_bit_cnt  <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_rx_data   <= w_rx_next;
            r_rx_valid  <= 1'b1;
            r_rx_first  <= r_first;
            r_tx_req    <= 1'b1;
            r_first     <= 1'b0;
            r_load_pend <= 1'b1;
            if (r_byte_count != 16'hFFFF) begin
              r_byte_count <= r_byte_count + 16'd1;
            end
          end
        end else if (w_sck_fall) begin
          // The fall after a completed byte brings in the backend's answer.
          if (r_load_pend) begin
            r_tx_shift  <= tx_data;
            r_load_pend <= 1'b0;
          end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign sdo        = (r_state == S_ACTIVE) & r_tx_shift[7];
  assign sdo_oe     = (r_state == S_ACTIVE);
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign rx_first   = r_rx_first;
  assign tx_req     = r_tx_req;
  assign frame_end  = r_frame_end;
  assign rx_abort   = r_rx_abort;
  assign byte_count = r_byte_count;

endmodule

// File: tb/tb_spi_sync_frontend.sv
`timescale 1ns/1ps
// Directed bench for spi_sync_frontend: an SPI mode-0 master model, a backend
// that answers tx_req from a table, and an event monitor.
module tb_spi_sync_frontend;

  localparam int SYNC_STAGES = 2;
  localparam int H_NOM = 8;
  localparam int H_MIN = SYNC_STAGES + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        ss_n = 1'b1;
  logic        sdi = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        sdo, sdo_oe, rx_valid, rx_first, tx_req, frame_end, rx_abort;
  logic [7:0]  rx_data;
  logic [15:0] byte_count;

  spi_sync_frontend #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_first(rx_first), .tx_data(tx_data), .tx_req(tx_req),
    .frame_end(frame_end), .rx_abort(rx_abort), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int half = H_NOM;

  // Monitor-owned state
  int cnt_valid = 0, cnt_txreq = 0, cnt_fend = 0, cnt_abort = 0, cnt_both = 0;
  int cnt_idle_drive = 0;
  int bk_rd = 0;
  int preset_ack = 0;
  logic [7:0] rx_log[$];
  logic       first_log[$];

  // Main-owned state
  logic [7:0] bk_arr[0:511];
  int preset_seq = 0;
  logic [7:0] preset_val = 8'h00;
  logic idle_watch = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        cnt_valid++;
        rx_log.push_back(rx_data);
        first_log.push_back(rx_first);
      end
      if (tx_req) begin
        cnt_txreq++;
        tx_data = bk_arr[bk_rd % 512];
        bk_rd++;
      end else if (preset_ack != preset_seq) begin
        tx_data = preset_val;
        preset_ack = preset_seq;
      end
      if (frame_end) cnt_fend++;
      if (rx_abort) cnt_abort++;
      if (rx_abort && frame_end) cnt_both++;
      if (idle_watch && (sdo || sdo_oe)) cnt_idle_drive++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_tx(input logic [7:0] v);
    preset_val = v;
    preset_seq++;
    wait_clk(2);
  endtask

  task automatic bit_xfer(input logic b, output logic miso);
    sdi = b;
    wait_clk(half);
    miso = sdo;
    sck = 1'b1;
    wait_clk(half);
    sck = 1'b0;
  endtask

  task automatic byte_xfer(input logic [7:0] mosi, output logic [7:0] miso);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(mosi[i], m);
      miso[i] = m;
    end
  endtask

  task automatic frame_begin();
    ss_n = 1'b0;
    wait_clk(half);
  endtask

  task automatic frame_finish();
    wait_clk(half);
    ss_n = 1'b1;
    wait_clk(half + 4);
  endtask

  initial begin
    logic [7:0] miso;
    logic       mb;
    int s_valid, s_txreq, s_fend, s_abort, s_both, s_drive, idx, base;
    logic [7:0] exp_b;

    wait_clk(3);
    check("rst_sdo", sdo, 1'b0);
    check("rst_sdo_oe", sdo_oe, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_byte_count", byte_count, 16'h0000);
    check("rst_pulses", {rx_valid, rx_first, tx_req, frame_end, rx_abort}, 5'b0);
    rst = 1'b0;
    wait_clk(10);

    // Single byte
    set_tx(8'hA5);
    s_valid = cnt_valid; s_txreq = cnt_txreq; s_fend = cnt_fend; s_abort = cnt_abort;
    idx = rx_log.size();
    frame_begin();
    check("t1_oe_active", sdo_oe, 1'b1);
    byte_xfer(8'h3C, miso);
    check("t1_miso", miso, 8'hA5);
    check("t1_rx_data", rx_data, 8'h3C);
    frame_finish();
    check("t1_valid_cnt", cnt_valid - s_valid, 1);
    check("t1_rx_first", first_log[idx], 1'b1);
    check("t1_txreq_cnt", cnt_txreq - s_txreq, 1);
    check("t1_fend_cnt", cnt_fend - s_fend, 1);
    check("t1_abort_cnt", cnt_abort - s_abort, 0);
    check("t1_byte_count", byte_count, 16'd1);
    check("t1_oe_idle", sdo_oe, 1'b0);

    // Three-byte frame
    base = bk_rd;
    bk_arr[(base + 0) % 512] = 8'h11;
    bk_arr[(base + 1) % 512] = 8'h22;
    bk_arr[(base + 2) % 512] = 8'h33;
    set_tx(8'hA5);
    s_valid = cnt_valid;
    idx = rx_log.size();
    frame_begin();
    byte_xfer(8'h01, miso); check("t2_miso0", miso, 8'hA5);
    byte_xfer(8'h02, miso); check("t2_miso1", miso, 8'h11);
    byte_xfer(8'h03, miso); check("t2_miso2", miso, 8'h22);
    frame_finish();
    check("t2_valid_cnt", cnt_valid - s_valid, 3);
    check("t2_rx0", rx_log[idx], 8'h01);
    check("t2_rx1", rx_log[idx + 1], 8'h02);
    check("t2_rx2", rx_log[idx + 2], 8'h03);
    check("t2_first", {first_log[idx], first_log[idx + 1], first_log[idx + 2]}, 3'b100);
    check("t2_byte_count", byte_count, 16'd3);

    // Abort after one full byte plus five bits
    set_tx(8'h5A);
    s_valid = cnt_valid; s_fend = cnt_fend; s_abort = cnt_abort; s_both = cnt_both;
    frame_begin();
    byte_xfer(8'hC3, miso);
    check("t3_miso", miso, 8'h5A);
    for (int i = 0; i < 5; i++) bit_xfer(1'b1, mb);
    frame_finish();
    check("t3_abort_cnt", cnt_abort - s_abort, 1);
    check("t3_fend_cnt", cnt_fend - s_fend, 1);
    check("t3_same_cycle", cnt_both - s_both, 1);
    check("t3_valid_cnt", cnt_valid - s_valid, 1);
    check("t3_byte_count", byte_count, 16'd1);
    check("t3_rx_hold", rx_data, 8'hC3);

    // sck activity with ss_n high
    s_valid = cnt_valid; s_drive = cnt_idle_drive;
    idle_watch = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sdi = ~sdi;
      sck = 1'b1; wait_clk(half);
      sck = 1'b0; wait_clk(half);
    end
    idle_watch = 1'b0;
    check("t4_valid_cnt", cnt_valid - s_valid, 0);
    check("t4_idle_drive", cnt_idle_drive - s_drive, 0);
    check("t4_byte_count", byte_count, 16'd1);

    // Reset in the middle of a frame
    set_tx(8'hA5);
    s_valid = cnt_valid; s_fend = cnt_fend; s_abort = cnt_abort;
    frame_begin();
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, mb);
    rst = 1'b1;
    wait_clk(4);
    check("t5_rst_count", byte_count, 16'd0);
    check("t5_rst_oe", sdo_oe, 1'b0);
    rst = 1'b0;
    wait_clk(2 * half);
    check("t5_no_restart", sdo_oe, 1'b0);
    ss_n = 1'b1;
    wait_clk(half);
    check("t5_no_fend", cnt_fend - s_fend, 0);
    check("t5_no_abort", cnt_abort - s_abort, 0);
    check("t5_no_valid", cnt_valid - s_valid, 0);
    idx = rx_log.size();
    frame_begin();
    byte_xfer(8'hFF, miso);
    check("t5_miso", miso, 8'hA5);
    frame_finish();
    check("t5_rx_data", rx_data, 8'hFF);
    check("t5_rx_first", first_log[idx], 1'b1);
    check("t5_fend_cnt", cnt_fend - s_fend, 1);

    // 256 bytes at the minimum sck half-period
    half = H_MIN;
    base = bk_rd;
    for (int k = 0; k < 256; k++) bk_arr[(base + k) % 512] = 8'(k * 7 + 3);
    set_tx(8'hA5);
    s_valid = cnt_valid;
    idx = rx_log.size();
    frame_begin();
    for (int i = 0; i < 256; i++) begin
      byte_xfer(8'(i) ^ 8'h5A, miso);
      exp_b = (i == 0) ? 8'hA5 : 8'((i - 1) * 7 + 3);
      check($sformatf("t6_miso%0d", i), miso, exp_b);
    end
    frame_finish();
    check("t6_valid_cnt", cnt_valid - s_valid, 256);
    for (int i = 0; i < 256; i++) begin
      if (idx + i < rx_log.size()) begin
        check($sformatf("t6_rx%0d", i), rx_log[idx + i], 8'(i) ^ 8'h5A);
      end
    end
    check("t6_byte_count", byte_count, 16'd256);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
